// File: rtl/microsequencer_if.sv
// Microsequencer bus: microstore/encoder inputs and sequencing outputs.
//   slave  : the sequencer (consumes next-state controls, drives state/status)
//   master : the controller or bench (drives controls, observes state/status)
//   enc_state    10  decoded microstate for the current instruction
//   ns_sel        3  next-state select from the microstore word
//   cr_addr      10  jump target from the microstore word
//   cond, inv     1  condition-tester result and its inversion
//   moc_wait      1  current state waits on memory-operation-complete
//   moc           1  memory operation complete
//   state_number 10  current microstate (registered)
//   stalled       1  state is being held waiting on moc (combinational)
//   timeout       1  sticky memory-timeout flag
interface microsequencer_if;
  localparam int unsigned SW = 10;
  localparam int unsigned NW = 3;

  logic [SW-1:0] enc_state;
  logic [NW-1:0] ns_sel;
  logic [SW-1:0] cr_addr;
  logic          cond;
  logic          inv;
  logic          moc_wait;
  logic          moc;
  logic [SW-1:0] state_number;
  logic          stalled;
  logic          timeout;

  modport slave (
    input  enc_state, ns_sel, cr_addr, cond, inv, moc_wait, moc,
    output state_number, stalled, timeout
  );

  modport master (
    output enc_state, ns_sel, cr_addr, cond, inv, moc_wait, moc,
    input  state_number, stalled, timeout
  );
endinterface

// File: rtl/microsequencer.sv
// Microsequencer: selects the next microstate from the microstore word, holds
// while a memory operation is outstanding, and jumps to ERR_STATE if the
// memory does not respond within MOC_TIMEOUT cycles.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : microsequencer_if.slave (controls in, state/status out)
module microsequencer #(
  parameter logic [9:0]  FETCH_STATE = 10'd1,
  parameter logic [9:0]  ERR_STATE   = 10'd1023,
  parameter int unsigned MOC_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  microsequencer_if.slave    bus
);
  localparam int unsigned SW = 10;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(MOC_TIMEOUT - 1);

  logic [SW-1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic [SW-1:0] sel_ns;
  logic [SW-1:0] inc_ns;
  logic          wait_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state selection and stall/timeout handling
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    inc_ns    = state_q + SW'(1);
    wait_c    = bus.moc_wait & ~bus.moc;

    unique case (bus.ns_sel)
      3'b000:  sel_ns = bus.enc_state;
      3'b001:  sel_ns = inc_ns;
      3'b010:  sel_ns = bus.cr_addr;
      3'b011:  sel_ns = (bus.cond ^ bus.inv) ? bus.cr_addr : inc_ns;
      default: sel_ns = FETCH_STATE;
    endcase

    if (wait_c) begin
      // Last permitted stall cycle with no moc: abandon to the error state
      if (cnt_q == CNT_LAST) begin
        state_d   = ERR_STATE;
        cnt_d     = '0;
        timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      state_d = sel_ns;
      cnt_d   = '0;
    end
  end

  // Outputs; stalled follows the live inputs but is forced low in reset
  always_comb begin
    bus.stalled      = 1'b0;
    if (!reset) bus.stalled = bus.moc_wait & ~bus.moc;
    bus.state_number = state_q;
    bus.timeout      = timeout_q;
  end
endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 The block SHALL have parameter FETCH_STATE, default 10'd1, which is the first microstate of instruction fetch.
REQ-002 The block SHALL have parameter ERR_STATE, default 10'd1023, which is the microstate entered on a memory timeout.
REQ-003 The block SHALL have parameter MOC_TIMEOUT, default 16, which is the maximum number of stall cycles allowed while waiting on MOC (legal range 2..255).
REQ-004 clk  input  1  The single clock; all state updates occur on its rising edge.
REQ-005 reset  input  1  Asynchronous, active-high reset.
REQ-006 enc_state  input  10  Decoded microstate for the current instruction, supplied combinationally by the instruction encoder.
REQ-007 ns_sel  input  3  Next-state select from the microstore word of the current state.
REQ-008 cr_addr  input  10  Jump target from the microstore word.
REQ-009 cond  input  1  Condition-tester result.
REQ-010 inv  input  1  Inverts cond when set.
REQ-011 moc_wait  input  1  The current state requires memory-operation-complete before it advances.
REQ-012 moc  input  1  Memory operation complete.
REQ-013 state_number  output  10  Current microstate, used to address the microstore; registered.
REQ-014 stalled  output  1  High for every cycle in which the state is held waiting on moc.
REQ-015 timeout  output  1  Sticky memory-timeout flag.

Function
REQ-016 The block SHALL compute next state from ns_sel as follows:
- 000: enc_state
- 001: state_number+1
- 010: cr_addr
- 011: cr_addr if (cond XOR inv)=1, else state_number+1
- 100: FETCH_STATE
- 101..111: FETCH_STATE
REQ-017 Increment SHALL be 10-bit modulo: 10'd1023+1 = 10'd0, with no carry-out.
REQ-018 state_number SHALL register the selected next state one clock after selection; the latency from enc_state to state_number SHALL be exactly 1 cycle.
REQ-019 Wait handling when moc_wait=1 and moc=0:
- state_number holds.
- stalled=1, combinationally from the current inputs.
- The stall counter increments by 1.
REQ-020 When moc_wait=1 and moc=1, the block SHALL advance per REQ-016 that cycle, clear the stall counter, and set stalled=0.
REQ-021 When moc_wait=0, the block SHALL ignore moc, advance every cycle, and hold the stall counter at 0.
REQ-022 Timeout: if the stall counter reaches MOC_TIMEOUT-1 and moc is still 0 on that cycle:
- The next edge SHALL load ERR_STATE.
- timeout SHALL be set to 1.
- The stall counter SHALL clear.
REQ-023 If moc=1 on the same cycle the counter reaches MOC_TIMEOUT-1, moc SHALL win: a normal advance occurs and timeout is not set.
REQ-024 timeout SHALL remain 1 until reset; once set it SHALL NOT alter sequencing, and normal next-state selection SHALL resume from ERR_STATE.
REQ-025 The stall counter SHALL be 8 bits wide and SHALL never wrap, because it clears at MOC_TIMEOUT-1.
REQ-026 Changes on enc_state, cond or cr_addr during a stall SHALL be ignored until the advance cycle; the values present on the advance cycle are the ones used.

Reset
REQ-027 While reset=1, asynchronously, the block SHALL force:
- state_number=10'd0
- stall counter=0
- timeout=0
- stalled=0, regardless of moc_wait and moc
REQ-028 On the first rising clk edge after reset deasserts, the block SHALL apply REQ-016 to the inputs present.
REQ-029 Reset asserted mid-stall or mid-timeout SHALL abort immediately with no pending advance retained.

Verification
REQ-030 Reset, then ns_sel=100 for 1 cycle -> state_number=1; then ns_sel=000 with enc_state=20 -> state_number=20 after 1 edge.
REQ-031 state_number=1023, ns_sel=001 -> 0; ns_sel=011, cr_addr=12, cond=1, inv=0 -> 12; same with inv=1 -> 13.
REQ-032 state_number=30, ns_sel=001, moc_wait=1, moc=0 for 5 cycles, then moc=1 -> state holds 30 with stalled=1 for 5 cycles, then 31 on the 6th edge; stalled=0 afterwards.
REQ-033 moc_wait=1, moc=0 held with MOC_TIMEOUT=16 -> state_number=1023 and timeout=1 on the 16th edge; timeout stays 1 across subsequent ns_sel=100 cycles.
REQ-034 moc rises exactly on the 16th stall cycle -> normal advance and timeout=0.
REQ-035 reset pulsed asynchronously mid-stall, between clock edges -> state_number=0, stalled=0 and counter=0 immediately, with no clock edge required.
